// File: rtl/noc_flit_pkg.sv
// Flit layout and sink FSM encoding shared by the NoC traffic harness blocks.
package noc_flit_pkg;
    localparam int FLIT_W    = 38;
    localparam int VALID_BIT = 37;
    localparam int TAIL_BIT  = 36;
    localparam int DEST_LSB  = 33;
    localparam int TS_MSB    = 31;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FLUSH  = 2'd1,
        REPORT = 2'd2,
        FIN    = 2'd3
    } sink_state_e;
endpackage

// File: rtl/pe_lat_accum.sv
// Per-packet latency (counter - tx timestamp, mod 2^32) with saturating sum and min/max tracking.
module pe_lat_accum (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_counter,
    input  logic [31:0] i_ts,
    input  logic        i_update,
    output logic [47:0] o_lat_sum,
    output logic [31:0] o_lat_min,
    output logic [31:0] o_lat_max
);
    logic [31:0] lat;
    logic [48:0] sum_ext;
    logic [47:0] sum_q, sum_d;
    logic [31:0] min_q, min_d;
    logic [31:0] max_q, max_d;

    always_comb begin
        lat     = i_counter - i_ts;
        sum_ext = {1'b0, sum_q} + {17'b0, lat};
        sum_d   = sum_q;
        min_d   = min_q;
        max_d   = max_q;
        if (i_update) begin
            sum_d = sum_ext[48] ? '1 : sum_ext[47:0];
            min_d = (lat < min_q) ? lat : min_q;
            max_d = (lat > max_q) ? lat : max_q;
        end
    end

    // min resets to all-ones so an empty run reports the "no data" sentinel
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sum_q <= '0;
            min_q <= '1;
            max_q <= '0;
        end else begin
            sum_q <= sum_d;
            min_q <= min_d;
            max_q <= max_d;
        end
    end

    assign o_lat_sum = sum_q;
    assign o_lat_min = min_q;
    assign o_lat_max = max_q;
endmodule

// File: rtl/pe_traffic_sink.sv
// Receive end of the PE traffic interface: destination check, packet/misroute counting,
// ready throttling and the done -> flush -> report sequence.
module pe_traffic_sink
    import noc_flit_pkg::*;
#(
    parameter int ADDRESS      = 0,
    parameter int ADDR_W       = 3,
    parameter int READY_PERIOD = 0,
    parameter int QUIET_CYCLES = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [FLIT_W-1:0] i_data,
    input  logic              i_data_valid,
    output logic              o_data_ready,
    input  logic              done,
    output logic [31:0]       o_pkt_count,
    output logic [47:0]       o_lat_sum,
    output logic [31:0]       o_lat_min,
    output logic [31:0]       o_lat_max,
    output logic [15:0]       o_misroute,
    output logic              o_report_valid,
    output logic              o_finished
);
    localparam logic [ADDR_W-1:0] ADDR_V     = ADDR_W'(ADDRESS);
    localparam logic [31:0]       STALL_LAST = 32'(READY_PERIOD - 1);
    localparam logic [31:0]       QUIET_LAST = 32'(QUIET_CYCLES - 1);

    sink_state_e state_q, state_d;
    logic [31:0] counter_q, counter_d;
    logic [31:0] stall_q, stall_d;
    logic [31:0] quiet_q, quiet_d;
    logic [31:0] pkt_count_q, pkt_count_d;
    logic [15:0] misroute_q, misroute_d;
    logic        done_q;
    logic        ready;
    logic        xfer;
    logic        dest_ok;
    logic        stats_open;
    logic        pkt_upd;

    wire unused_rsvd = i_data[32];

    always_comb begin
        stall_d = '0;
        ready   = 1'b1;
        if (READY_PERIOD > 0) begin
            if (stall_q == STALL_LAST) begin
                ready = 1'b0;
            end else begin
                stall_d = stall_q + 32'd1;
            end
        end
    end

    always_comb begin
        counter_d   = counter_q + 32'd1;
        xfer        = i_data_valid & ready;
        dest_ok     = i_data[VALID_BIT] && (i_data[DEST_LSB +: ADDR_W] == ADDR_V);
        stats_open  = (state_q == RUN) || (state_q == FLUSH);
        pkt_upd     = xfer && dest_ok && i_data[TAIL_BIT] && stats_open;
        pkt_count_d = pkt_count_q;
        misroute_d  = misroute_q;
        if (pkt_upd && (pkt_count_q != '1)) begin
            pkt_count_d = pkt_count_q + 32'd1;
        end
        // misroutes keep counting even after the report has been issued
        if (xfer && !dest_ok && (misroute_q != '1)) begin
            misroute_d = misroute_q + 16'd1;
        end
    end

    always_comb begin
        state_d = state_q;
        quiet_d = quiet_q;
        unique case (state_q)
            RUN: begin
                if (done && !done_q) begin
                    state_d = FLUSH;
                    quiet_d = '0;
                end
            end
            FLUSH: begin
                if (xfer) begin
                    quiet_d = '0;
                end else if (quiet_q == QUIET_LAST) begin
                    state_d = REPORT;
                end else begin
                    quiet_d = quiet_q + 32'd1;
                end
            end
            REPORT:  state_d = FIN;
            FIN:     state_d = FIN;
            default: state_d = RUN;
        endcase
    end

    // done_q resets high so a done already asserted at reset release is not an edge
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= RUN;
            counter_q   <= '0;
            stall_q     <= '0;
            quiet_q     <= '0;
            pkt_count_q <= '0;
            misroute_q  <= '0;
            done_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            counter_q   <= counter_d;
            stall_q     <= stall_d;
            quiet_q     <= quiet_d;
            pkt_count_q <= pkt_count_d;
            misroute_q  <= misroute_d;
            done_q      <= done;
        end
    end

    pe_lat_accum u_lat_accum (
        .clk       (clk),
        .rst       (rst),
        .i_counter (counter_q),
        .i_ts      (i_data[TS_MSB:0]),
        .i_update  (pkt_upd),
        .o_lat_sum (o_lat_sum),
        .o_lat_min (o_lat_min),
        .o_lat_max (o_lat_max)
    );

    assign o_data_ready   = ready;
    assign o_pkt_count    = pkt_count_q;
    assign o_misroute     = misroute_q;
    assign o_report_valid = (state_q == REPORT);
    assign o_finished     = (state_q == FIN);
endmodule

// File: tb/tb_pe_traffic_sink.sv
// Directed self-checking bench for pe_traffic_sink: vector table plus hand-written
// back-to-back, wrap, throttle and flush/report sequences.
module tb_pe_traffic_sink;
    logic        clk;
    logic        rst;
    logic [37:0] i_data;
    logic        i_data_valid;
    logic        done;
    logic        o_data_ready;
    logic [31:0] o_pkt_count;
    logic [47:0] o_lat_sum;
    logic [31:0] o_lat_min;
    logic [31:0] o_lat_max;
    logic [15:0] o_misroute;
    logic        o_report_valid;
    logic        o_finished;

    logic [37:0] thr_data;
    logic        thr_valid;
    logic        thr_ready;
    logic [31:0] thr_pkt_count;
    logic [47:0] thr_lat_sum;
    logic [31:0] thr_lat_min;
    logic [31:0] thr_lat_max;
    logic [15:0] thr_misroute;
    logic        thr_report_valid;
    logic        thr_finished;

    logic [31:0] tb_cnt;
    int          tests_run;
    int          tests_failed;

    typedef struct {
        logic        vtag;
        logic        tail;
        logic [2:0]  dest;
        logic [31:0] lat;
        logic [31:0] exp_count;
        logic [47:0] exp_sum;
        logic [31:0] exp_min;
        logic [31:0] exp_max;
        logic [15:0] exp_mis;
    } vec_t;

    vec_t vecs[5];

    pe_traffic_sink #(
        .ADDRESS(2), .ADDR_W(3), .READY_PERIOD(0), .QUIET_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst), .i_data(i_data), .i_data_valid(i_data_valid),
        .o_data_ready(o_data_ready), .done(done), .o_pkt_count(o_pkt_count),
        .o_lat_sum(o_lat_sum), .o_lat_min(o_lat_min), .o_lat_max(o_lat_max),
        .o_misroute(o_misroute), .o_report_valid(o_report_valid), .o_finished(o_finished)
    );

    pe_traffic_sink #(
        .ADDRESS(2), .ADDR_W(3), .READY_PERIOD(4), .QUIET_CYCLES(16)
    ) dut_thr (
        .clk(clk), .rst(rst), .i_data(thr_data), .i_data_valid(thr_valid),
        .o_data_ready(thr_ready), .done(1'b0), .o_pkt_count(thr_pkt_count),
        .o_lat_sum(thr_lat_sum), .o_lat_min(thr_lat_min), .o_lat_max(thr_lat_max),
        .o_misroute(thr_misroute), .o_report_valid(thr_report_valid), .o_finished(thr_finished)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference timestamp counter: cleared by reset, +1 on every clock
    always @(posedge clk or negedge rst) begin
        if (!rst) tb_cnt <= '0;
        else      tb_cnt <= tb_cnt + 32'd1;
    end

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic vtag, input logic tail, input logic [2:0] dest,
                                 input logic [31:0] ts);
        i_data       = {vtag, tail, dest, 1'b0, ts};
        i_data_valid = 1'b1;
        step();
        i_data_valid = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b0;
        step();
        rst = 1'b1;
    endtask

    task automatic checkStats(input string tag, input logic [31:0] c, input logic [47:0] s,
                              input logic [31:0] mn, input logic [31:0] mx, input logic [15:0] mis);
        checkOutput({tag, "_count"}, 64'(o_pkt_count), 64'(c));
        checkOutput({tag, "_sum"},   64'(o_lat_sum),   64'(s));
        checkOutput({tag, "_min"},   64'(o_lat_min),   64'(mn));
        checkOutput({tag, "_max"},   64'(o_lat_max),   64'(mx));
        checkOutput({tag, "_mis"},   64'(o_misroute),  64'(mis));
    endtask

    initial begin
        int guard;
        int rep_k;
        int rep_pulses;
        int xfers;
        int lows;
        int first_low;
        int bad_spacing;

        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b0;
        done         = 1'b0;
        i_data       = '0;
        i_data_valid = 1'b0;
        thr_data     = '0;
        thr_valid    = 1'b0;

        vecs[0] = '{1'b1, 1'b1, 3'd2, 32'd20, 32'd2, 48'd30, 32'd10, 32'd20, 16'd0};
        vecs[1] = '{1'b1, 1'b1, 3'd2, 32'd4,  32'd3, 48'd34, 32'd4,  32'd20, 16'd0};
        vecs[2] = '{1'b1, 1'b0, 3'd2, 32'd1,  32'd3, 48'd34, 32'd4,  32'd20, 16'd0};
        vecs[3] = '{1'b1, 1'b1, 3'd5, 32'd2,  32'd3, 48'd34, 32'd4,  32'd20, 16'd1};
        vecs[4] = '{1'b0, 1'b1, 3'd2, 32'd1,  32'd3, 48'd34, 32'd4,  32'd20, 16'd2};

        repeat (3) step();
        checkStats("reset", 32'd0, 48'd0, 32'hFFFF_FFFF, 32'd0, 16'd0);
        checkOutput("reset_report", 64'(o_report_valid), 64'd0);
        checkOutput("reset_fin",    64'(o_finished),     64'd0);
        checkOutput("reset_ready",  64'(o_data_ready),   64'd1);
        rst = 1'b1;

        guard = 0;
        while (tb_cnt != 32'd100 && guard < 500) begin
            step();
            guard++;
        end
        checkOutput("reach_cnt100", 64'(tb_cnt), 64'd100);
        applyStimulus(1'b1, 1'b1, 3'd2, 32'd90);
        checkStats("t1", 32'd1, 48'd10, 32'd10, 32'd10, 16'd0);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(vecs[i].vtag, vecs[i].tail, vecs[i].dest, tb_cnt - vecs[i].lat);
            checkStats($sformatf("vec%0d", i), vecs[i].exp_count, vecs[i].exp_sum,
                       vecs[i].exp_min, vecs[i].exp_max, vecs[i].exp_mis);
        end

        doReset();
        guard = 0;
        while (tb_cnt != 32'd4 && guard < 50) begin
            step();
            guard++;
        end
        applyStimulus(1'b1, 1'b1, 3'd2, 32'hFFFF_FFFA);
        checkStats("wrap", 32'd1, 48'd10, 32'd10, 32'd10, 16'd0);

        i_data_valid = 1'b1;
        i_data = {1'b1, 1'b1, 3'd2, 1'b0, tb_cnt - 32'd5};
        checkOutput("b2b_ready0", 64'(o_data_ready), 64'd1);
        step();
        i_data = {1'b1, 1'b1, 3'd2, 1'b0, tb_cnt - 32'd3};
        checkOutput("b2b_ready1", 64'(o_data_ready), 64'd1);
        step();
        i_data = {1'b1, 1'b1, 3'd2, 1'b0, tb_cnt - 32'd9};
        checkOutput("b2b_ready2", 64'(o_data_ready), 64'd1);
        step();
        i_data_valid = 1'b0;
        checkStats("b2b", 32'd4, 48'd27, 32'd3, 32'd10, 16'd0);

        doReset();
        repeat (2) step();
        done = 1'b1;
        step();
        repeat (4) step();
        applyStimulus(1'b1, 1'b1, 3'd5, tb_cnt);
        rep_k      = -1;
        rep_pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            if (o_report_valid) begin
                rep_pulses++;
                if (rep_k < 0) rep_k = k;
            end
            step();
        end
        checkOutput("report_cycle",  64'(rep_k),      64'd17);
        checkOutput("report_pulses", 64'(rep_pulses), 64'd1);
        checkOutput("finished",      64'(o_finished), 64'd1);
        checkStats("flush", 32'd0, 48'd0, 32'hFFFF_FFFF, 32'd0, 16'd1);
        applyStimulus(1'b1, 1'b1, 3'd2, tb_cnt - 32'd7);
        applyStimulus(1'b1, 1'b1, 3'd6, tb_cnt);
        checkStats("fin_frozen", 32'd0, 48'd0, 32'hFFFF_FFFF, 32'd0, 16'd2);

        rst = 1'b0;
        #1;
        checkStats("midrst", 32'd0, 48'd0, 32'hFFFF_FFFF, 32'd0, 16'd0);
        checkOutput("midrst_fin", 64'(o_finished), 64'd0);
        step();
        rst = 1'b1;
        repeat (30) step();
        checkOutput("done_at_release", 64'(o_finished), 64'd0);
        done = 1'b0;

        doReset();
        thr_data  = {1'b1, 1'b1, 3'd2, 1'b0, 32'd0};
        thr_valid = 1'b1;
        xfers       = 0;
        lows        = 0;
        first_low   = -1;
        bad_spacing = 0;
        for (int c = 0; c < 16; c++) begin
            if (thr_ready) begin
                xfers++;
            end else begin
                lows++;
                if (first_low < 0) first_low = c;
                else if (((c - first_low) % 4) != 0) bad_spacing++;
            end
            step();
        end
        thr_valid = 1'b0;
        checkOutput("thr_xfers",   64'(xfers),         64'd12);
        checkOutput("thr_lows",    64'(lows),          64'd4);
        checkOutput("thr_spacing", 64'(bad_spacing),   64'd0);
        checkOutput("thr_count",   64'(thr_pkt_count), 64'd12);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
